// File: rtl/data_memory_responder.sv
// Wait-state data-memory responder: one outstanding load/store, serviced after LATENCY cycles.
// Optional macro RESPONDER_BACK_TO_BACK_EN lets a new request be accepted in the response-handshake cycle.
//
// state   | meaning
// IDLE    | ready for a request
// WAIT    | request latched, counting down wait states
// RESPOND | access done, holding response until RespReady
module data_memory_responder #(
  parameter int XLEN              = 32,
  parameter int MEMORY_SIZE_WORDS = 64,
  parameter int LATENCY           = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWriteEn,
  input  logic [XLEN/8-1:0] ReqByteEn,
  input  logic [XLEN-1:0]   ReqAdr,
  input  logic [XLEN-1:0]   ReqWriteData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [XLEN-1:0]   RespReadData,
  output logic              RespError
);

  localparam int NB     = XLEN / 8;
  localparam int OFF_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDX_W  = XLEN - OFF_W;
  localparam int MEM_AW = (MEMORY_SIZE_WORDS > 1) ? $clog2(MEMORY_SIZE_WORDS) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   adr_q, adr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [XLEN-1:0]   mem_q [MEMORY_SIZE_WORDS];

  logic              req_ready;
  logic              accept;
  logic              resp_hs;
  logic              do_access;
  logic              mem_we;
  logic              acc_we;
  logic [NB-1:0]     acc_be;
  logic [XLEN-1:0]   acc_adr;
  logic [XLEN-1:0]   acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic [MEM_AW-1:0] acc_widx;
  logic              acc_err;

`ifdef RESPONDER_BACK_TO_BACK_EN
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESPOND) && RespReady);
`else
  assign req_ready = (state_q == S_IDLE);
`endif

  assign accept  = ReqValid && req_ready;
  assign resp_hs = (state_q == S_RESPOND) && RespReady;

  // With LATENCY=0 the access happens on the accepting edge, so use the live request.
  always_comb begin
    if (accept) begin
      acc_we    = ReqWriteEn;
      acc_be    = ReqByteEn;
      acc_adr   = ReqAdr;
      acc_wdata = ReqWriteData;
    end else begin
      acc_we    = we_q;
      acc_be    = be_q;
      acc_adr   = adr_q;
      acc_wdata = wdata_q;
    end
    acc_idx  = acc_adr[XLEN-1:OFF_W];
    acc_widx = acc_idx[MEM_AW-1:0];
    acc_err  = (acc_adr[OFF_W-1:0] != '0) || (acc_idx >= IDX_W'(MEMORY_SIZE_WORDS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (LATENCY == 0) ? S_RESPOND : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_RESPOND;
      end
      S_RESPOND: begin
        if (resp_hs) begin
          if (accept) state_d = (LATENCY == 0) ? S_RESPOND : S_WAIT;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An access fires on every edge that enters RESPOND with a new request behind it.
  assign do_access = (state_d == S_RESPOND) && ((state_q != S_RESPOND) || accept);
  assign mem_we    = do_access && acc_we && !acc_err && reset;

  always_comb begin
    we_d    = we_q;
    be_d    = be_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    if (accept) begin
      we_d    = ReqWriteEn;
      be_d    = ReqByteEn;
      adr_d   = ReqAdr;
      wdata_d = ReqWriteData;
      cnt_d   = CNT_W'(LATENCY);
    end else if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - CNT_W'(1);
    end

    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (!acc_we && !acc_err) ? mem_q[acc_widx] : '0;
    end else if (resp_hs) begin
      err_d   = 1'b0;
      rdata_d = '0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) mem_q[acc_widx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    ReqReady     = req_ready;
    RespValid    = (state_q == S_RESPOND);
    RespReadData = rdata_q;
    RespError    = err_q;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (LATENCY=2, XLEN=32, 64 words).
// Expected values are hand-computed constants.
module tb_data_memory_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWriteEn;
  logic [3:0]  ReqByteEn;
  logic [31:0] ReqAdr;
  logic [31:0] ReqWriteData;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespReadData;
  logic        RespError;

  int total = 0;
  int bad   = 0;

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;

  data_memory_responder #(.XLEN(32), .MEMORY_SIZE_WORDS(64), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWriteEn   (ReqWriteEn),
    .ReqByteEn    (ReqByteEn),
    .ReqAdr       (ReqAdr),
    .ReqWriteData (ReqWriteData),
    .RespValid    (RespValid),
    .RespReady    (RespReady),
    .RespReadData (RespReadData),
    .RespError    (RespError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic we, input logic [3:0] be, input logic [31:0] adr,
                         input logic [31:0] wd);
    ReqValid     = 1'b1;
    ReqWriteEn   = we;
    ReqByteEn    = be;
    ReqAdr       = adr;
    ReqWriteData = wd;
  endtask

  // Waits (bounded) for RespValid; r_lat counts cycles since the acceptance cycle.
  task automatic wait_resp();
    while (!RespValid && r_lat < 40) begin
      step();
      r_lat++;
    end
    chk("resp_seen", RespValid, 1'b1);
    r_data = RespReadData;
    r_err  = RespError;
  endtask

  task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] adr,
                      input logic [31:0] wd);
    present(we, be, adr, wd);
    chk("req_ready_idle", ReqReady, 1'b1);
    step();
    ReqValid = 1'b0;
    r_lat    = 1;
    wait_resp();
    RespReady = 1'b1;
    step();
    chk("resp_dropped", RespValid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    ReqValid     = 1'b0;
    ReqWriteEn   = 1'b0;
    ReqByteEn    = 4'h0;
    ReqAdr       = 32'h0;
    ReqWriteData = 32'h0;
    RespReady    = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_req_ready", ReqReady, 1'b1);
    chk("rst_resp_valid", RespValid, 1'b0);
    chk("rst_rdata", RespReadData, 32'h0);
    chk("rst_err", RespError, 1'b0);

    xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    chk("st_lat", r_lat, LAT + 1);
    chk("st_rdata", r_data, 32'h0);
    chk("st_err", r_err, 1'b0);
    xact(1'b0, 4'h0, 32'h10, 32'h0);
    chk("ld_lat", r_lat, LAT + 1);
    chk("ld_data", r_data, 32'hDEADBEEF);
    chk("ld_err", r_err, 1'b0);

    xact(1'b1, 4'b0001, 32'h10, 32'h000000AA);
    xact(1'b0, 4'h0, 32'h10, 32'h0);
    chk("partial_lane0", r_data, 32'hDEADBEAA);
    xact(1'b1, 4'b1000, 32'h10, 32'h77000000);
    xact(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF);
    xact(1'b0, 4'h0, 32'h10, 32'h0);
    chk("partial_lane3_noop", r_data, 32'h77ADBEAA);

    xact(1'b0, 4'h0, 32'h11, 32'h0);
    chk("misalign_err", r_err, 1'b1);
    chk("misalign_data", r_data, 32'h0);
    xact(1'b0, 4'h0, 32'h100, 32'h0);
    chk("oor_err", r_err, 1'b1);
    chk("oor_data", r_data, 32'h0);
    xact(1'b1, 4'hF, 32'h13, 32'hFFFFFFFF);
    chk("misalign_st_err", r_err, 1'b1);
    xact(1'b1, 4'hF, 32'h0, 32'h01020304);
    xact(1'b1, 4'hF, 32'h100, 32'hFFFFFFFF);
    chk("oor_st_err", r_err, 1'b1);
    xact(1'b0, 4'h0, 32'h0, 32'h0);
    chk("oor_st_no_wrap", r_data, 32'h01020304);
    xact(1'b0, 4'h0, 32'h10, 32'h0);
    chk("err_no_write", r_data, 32'h77ADBEAA);

    // Response back-pressure with an ignored request pending.
    RespReady = 1'b0;
    present(1'b0, 4'h0, 32'h10, 32'h0);
    step();
    ReqValid = 1'b0;
    r_lat    = 1;
    wait_resp();
    chk("hold_lat", r_lat, LAT + 1);
    for (int i = 0; i < 5; i++) begin
      present(1'b1, 4'hF, 32'h10, 32'h0);
      step();
      chk("hold_valid", RespValid, 1'b1);
      chk("hold_data", RespReadData, 32'h77ADBEAA);
      chk("hold_req_ready", ReqReady, 1'b0);
    end
    ReqValid  = 1'b0;
    RespReady = 1'b1;
    step();
    chk("hold_release_valid", RespValid, 1'b0);
    chk("hold_release_ready", ReqReady, 1'b1);
    xact(1'b0, 4'h0, 32'h10, 32'h0);
    chk("hold_ignored_store", r_data, 32'h77ADBEAA);

    // Reset during WAIT of a store must drop it.
    xact(1'b1, 4'hF, 32'h20, 32'h12345678);
    present(1'b1, 4'hF, 32'h20, 32'h0BADF00D);
    step();
    ReqValid = 1'b0;
    chk("wait_no_valid", RespValid, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", ReqReady, 1'b1);
    chk("mid_rst_valid", RespValid, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    step();
    xact(1'b0, 4'h0, 32'h20, 32'h0);
    chk("rst_dropped_store", r_data, 32'h12345678);

    // Request presented in the response-handshake cycle.
    present(1'b0, 4'h0, 32'h20, 32'h0);
    step();
    ReqValid = 1'b0;
    r_lat    = 1;
    wait_resp();
    chk("first_data", r_data, 32'h12345678);
    present(1'b0, 4'h0, 32'h10, 32'h0);
`ifdef RESPONDER_BACK_TO_BACK_EN
    chk("b2b_ready", ReqReady, 1'b1);
    chk("b2b_spacing", r_lat, LAT + 1);
    step();
    ReqValid = 1'b0;
    r_lat    = 1;
    wait_resp();
    chk("b2b_lat", r_lat, LAT + 1);
    chk("b2b_data", r_data, 32'h77ADBEAA);
    step();
`else
    chk("no_b2b_ready", ReqReady, 1'b0);
    step();
    chk("no_b2b_idle_valid", RespValid, 1'b0);
    chk("no_b2b_idle_ready", ReqReady, 1'b1);
    step();
    ReqValid = 1'b0;
    r_lat    = 1;
    wait_resp();
    chk("no_b2b_lat", r_lat, LAT + 1);
    chk("no_b2b_data", r_data, 32'h77ADBEAA);
    step();
`endif
    chk("final_idle", ReqReady, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the core's data-memory port: accepts load/store requests over a ready/valid request channel, services them from an internal word-addressed array after a fixed number of wait states, and returns read data plus an error flag over a ready/valid response channel. It replaces the single-cycle data storage beside the compute core when exercising stall paths, with one outstanding request at a time.

## Interface
- XLEN, 32: data width in bits; byte lanes = XLEN/8
- MEMORY_SIZE_WORDS, 64: array depth in XLEN-bit words
- LATENCY, 2: wait-state cycles between request acceptance and response (0 allowed)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces all state to reset values
- ReqValid  in  1  request present
- ReqReady  out  1  responder can accept a request this cycle
- ReqWriteEn  in  1  1 = store, 0 = load
- ReqByteEn  in  XLEN/8  store byte-lane enables, ignored on loads
- ReqAdr  in  XLEN  byte address
- ReqWriteData  in  XLEN  store data
- RespValid  out  1  response present
- RespReady  in  1  consumer accepts response
- RespReadData  out  XLEN  load data; 0 for stores and errors
- RespError  out  1  misaligned or out-of-range access

## Operation
- States: IDLE, WAIT, RESPOND. Reset state IDLE.
- IDLE: ReqReady=1. On ReqValid&&ReqReady latch WriteEn, ByteEn, Adr, WriteData; go WAIT with counter=LATENCY, or RESPOND directly if LATENCY=0.
- WAIT: ReqReady=0; counter decrements each cycle; at counter==1 go RESPOND.
- Transition into RESPOND performs the access: word index = Adr >> log2(XLEN/8).
  - Error if Adr low log2(XLEN/8) bits nonzero, or index >= MEMORY_SIZE_WORDS; error accesses never write and return data 0.
  - Store: each lane i with ByteEn[i]=1 written; other lanes unchanged; RespReadData=0. ByteEn=0 is a legal no-op store.
  - Load: RespReadData = full word at index.
- RESPOND: RespValid=1, RespReadData/RespError stable until RespValid&&RespReady; then IDLE, RespValid=0.
- Request inputs ignored while ReqReady=0; requester holds them.
- Array contents are not cleared by reset; only control state and outputs reset.

## Timing
- Reset values: ReqReady=1, RespValid=0, RespReadData=0, RespError=0, state IDLE, counter 0.
- Request accepted at edge E0; RespValid rises after edge E0+LATENCY (LATENCY+1 cycles after acceptance cycle; LATENCY=0 gives RespValid in the next cycle).
- Store data visible to any request accepted after the store's response handshake.
- Minimum request-to-request spacing (macro off): LATENCY+2 cycles.
- RespReady held low: responder stays in RESPOND indefinitely, outputs frozen.
- Reset asserted mid-WAIT: request dropped, no write performed. Asserted in RESPOND: write already committed, response dropped.

## Configuration
- RESPONDER_BACK_TO_BACK_EN defined: in RESPOND, ReqReady = RespReady; a request presented in the response-handshake cycle is accepted in that same cycle and the block goes to WAIT (or RESPOND with fresh data if LATENCY=0) instead of IDLE; spacing drops to LATENCY+1 cycles.
- Undefined: ReqReady=1 only in IDLE; handshake always returns to IDLE first.

## Test plan
- Reset low 3 cycles, release -> ReqReady=1, RespValid=0, RespReadData=0, RespError=0.
- LATENCY=2: store 0xDEADBEEF to 0x10, ByteEn=4'hF; load 0x10 -> RespValid 3 cycles after each acceptance, load returns 0xDEADBEEF, RespError=0.
- Partial store 0x000000AA with ByteEn=4'b0001 to 0x10 over 0xDEADBEEF -> load returns 0xDEADBEAA.
- Load 0x11 (misaligned) and 0x100 (index 64) -> RespError=1, RespReadData=0; prior word at 0x10 unchanged.
- Hold RespReady=0 for 5 cycles on a load -> RespValid and data stable, ReqReady=0, new ReqValid ignored; release -> IDLE next cycle.
- Reset asserted in WAIT of a store to 0x20 after writing 0x12345678 there -> subsequent load returns 0x12345678; with RESPONDER_BACK_TO_BACK_EN, two loads issued back-to-back accept at LATENCY+1 spacing.
